// File: rtl/snp_req_handler.sv
// snp_req_handler
// Snoop request front end for the L1 array. It accepts one bus snoop at a time and looks up
// the direct-mapped tag/state/data array. It applies the MESI snoop transition, writes the new
// state back, and returns a snoop response carrying block data on a dirty/exclusive hit.
// Build option: define SNP_FAST_MISS_EN to send misses from LOOKUP straight to RESP.

`ifndef SUREQ_RD
`define SUREQ_RD 2'd0
`endif
`ifndef SUREQ_RFO
`define SUREQ_RFO 2'd1
`endif
`ifndef SUREQ_INV
`define SUREQ_INV 2'd2
`endif
`ifndef SDRSP_OKAY
`define SDRSP_OKAY 2'd0
`endif
`ifndef SDRSP_INV
`define SDRSP_INV 2'd1
`endif
// MESI encodings: bit 0 marks the states that own the only valid copy (E, M)
`ifndef INVALID
`define INVALID 3'd0
`endif
`ifndef EXCLUSIVE
`define EXCLUSIVE 3'd1
`endif
`ifndef SHARED
`define SHARED 3'd2
`endif
`ifndef MODIFIED
`define MODIFIED 3'd3
`endif

module snp_req_handler #(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned INDEX_WIDTH = 6,
    parameter int unsigned BLK_WIDTH   = 512,
    localparam int unsigned OFFSET_W   = $clog2(BLK_WIDTH / 8),
    localparam int unsigned TAG_W      = ADDR_WIDTH - INDEX_WIDTH - OFFSET_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   sureq_valid,
    output logic                   sureq_ready,
    input  logic [1:0]             sureq_op,
    input  logic [ADDR_WIDTH-1:0]  sureq_addr,
    input  logic                   cpu_lock,
    output logic                   arr_rd_en,
    output logic [INDEX_WIDTH-1:0] arr_idx,
    input  logic [TAG_W-1:0]       arr_rd_tag,
    input  logic [2:0]             arr_rd_st,
    input  logic [BLK_WIDTH-1:0]   arr_rd_data,
    output logic                   arr_wr_en,
    output logic [2:0]             arr_wr_st,
    output logic                   sdrsp_valid,
    input  logic                   sdrsp_ready,
    output logic [1:0]             sdrsp_rsp,
    output logic [BLK_WIDTH-1:0]   sdrsp_data
);

    typedef enum logic [1:0] {
        StIdle,
        StLookup,
        StUpdate,
        StResp
    } state_t;

    state_t                 r_state;
    logic [1:0]             r_op;
    logic [TAG_W-1:0]       r_tag;
    logic [INDEX_WIDTH-1:0] r_idx;
    logic                   r_hit;
    logic [2:0]             r_cur;
    logic [2:0]             r_next;
    logic                   r_rsp_valid;
    logic [1:0]             r_rsp;
    logic [BLK_WIDTH-1:0]   r_data;

    logic                   w_ready;
    logic                   w_accept;
    logic [INDEX_WIDTH-1:0] w_req_idx;
    logic [TAG_W-1:0]       w_req_tag;
    logic                   w_hit;
    logic [2:0]             w_cur;
    logic                   w_okay;
    logic [2:0]             w_next;
    logic                   w_unused_offset;

    // Address split; the block offset does not take part in a snoop lookup
    assign w_req_idx       = sureq_addr[OFFSET_W +: INDEX_WIDTH];
    assign w_req_tag       = sureq_addr[ADDR_WIDTH-1 -: TAG_W];
    assign w_unused_offset = ^sureq_addr[OFFSET_W-1:0];

    // Acceptance is gated by reset as well so ready stays low while rst is held
    assign w_ready  = (r_state == StIdle) && !cpu_lock && !rst;
    assign w_accept = w_ready && sureq_valid;

    // Lookup result, valid while in LOOKUP (array data arrives one cycle after the read)
    assign w_hit  = (arr_rd_tag == r_tag) && (arr_rd_st != `INVALID);
    assign w_cur  = w_hit ? arr_rd_st : `INVALID;
    assign w_okay = w_hit && w_cur[0] && ((r_op == `SUREQ_RD) || (r_op == `SUREQ_RFO));

    // MESI snoop transition: reads demote to SHARED, ownership/invalidate requests evict
    always_comb begin
        w_next = w_cur;
        case (r_op)
            `SUREQ_RD:  w_next = `SHARED;
            `SUREQ_RFO: w_next = `INVALID;
            `SUREQ_INV: w_next = `INVALID;
            default:    w_next = w_cur;
        endcase
    end

    // Request sequencing: IDLE -> LOOKUP -> UPDATE -> RESP, with registered response payload
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= StIdle;
            r_op        <= `SUREQ_RD;
            r_tag       <= '0;
            r_idx       <= '0;
            r_hit       <= 1'b0;
            r_cur       <= `INVALID;
            r_next      <= `INVALID;
            r_rsp_valid <= 1'b0;
            r_rsp       <= `SDRSP_INV;
            r_data      <= '0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (w_accept) begin
                        r_op    <= sureq_op;
                        r_tag   <= w_req_tag;
                        r_idx   <= w_req_idx;
                        r_state <= StLookup;
                    end
                end
                StLookup: begin
                    r_hit  <= w_hit;
                    r_cur  <= w_cur;
                    r_next <= w_next;
                    r_rsp  <= w_okay ? `SDRSP_OKAY : `SDRSP_INV;
                    r_data <= w_okay ? arr_rd_data : '0;
`ifdef SNP_FAST_MISS_EN
                    // A miss never writes, so it can skip the write slot entirely
                    if (!w_hit) begin
                        r_rsp_valid <= 1'b1;
                        r_state     <= StResp;
                    end else begin
                        r_state <= StUpdate;
                    end
`else
                    r_state <= StUpdate;
`endif
                end
                StUpdate: begin
                    r_rsp_valid <= 1'b1;
                    r_state     <= StResp;
                end
                StResp: begin
                    if (sdrsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_rsp       <= `SDRSP_INV;
                        r_data      <= '0;
                        r_state     <= StIdle;
                    end
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    // Array port: index comes straight from the request on the accept cycle, then is held
    assign sureq_ready = w_ready;
    assign arr_rd_en   = w_accept;
    assign arr_idx     = w_accept ? w_req_idx : r_idx;
    assign arr_wr_en   = (r_state == StUpdate) && r_hit && (r_next != r_cur);
    assign arr_wr_st   = r_next;

    // Response channel is driven purely from registers, so payload is stable while waiting
    assign sdrsp_valid = r_rsp_valid;
    assign sdrsp_rsp   = r_rsp;
    assign sdrsp_data  = r_data;

endmodule

// File: tb/tb_snp_req_handler.sv
// Self-checking bench for snp_req_handler: a bench-side array image answers reads, and a
// MESI snoop model predicts response, data, latency and state write-back for each request.

`ifndef SUREQ_RD
`define SUREQ_RD 2'd0
`endif
`ifndef SUREQ_RFO
`define SUREQ_RFO 2'd1
`endif
`ifndef SUREQ_INV
`define SUREQ_INV 2'd2
`endif
`ifndef SDRSP_OKAY
`define SDRSP_OKAY 2'd0
`endif
`ifndef SDRSP_INV
`define SDRSP_INV 2'd1
`endif
`ifndef INVALID
`define INVALID 3'd0
`endif
`ifndef EXCLUSIVE
`define EXCLUSIVE 3'd1
`endif
`ifndef SHARED
`define SHARED 3'd2
`endif
`ifndef MODIFIED
`define MODIFIED 3'd3
`endif

module tb_snp_req_handler;

    localparam int AW = 32;
    localparam int IW = 6;
    localparam int BW = 512;
    localparam int OW = 6;
    localparam int TW = AW - IW - OW;

    logic          clk = 1'b0;
    logic          rst;
    logic          sureq_valid;
    logic          sureq_ready;
    logic [1:0]    sureq_op;
    logic [AW-1:0] sureq_addr;
    logic          cpu_lock;
    logic          arr_rd_en;
    logic [IW-1:0] arr_idx;
    logic [TW-1:0] arr_rd_tag;
    logic [2:0]    arr_rd_st;
    logic [BW-1:0] arr_rd_data;
    logic          arr_wr_en;
    logic [2:0]    arr_wr_st;
    logic          sdrsp_valid;
    logic          sdrsp_ready;
    logic [1:0]    sdrsp_rsp;
    logic [BW-1:0] sdrsp_data;

    // Array image seen by the DUT
    logic [TW-1:0] mem_tag  [64];
    logic [2:0]    mem_st   [64];
    logic [BW-1:0] mem_data [64];

    int n_checks = 0;
    int n_errors = 0;

    snp_req_handler dut (
        .clk         (clk),
        .rst         (rst),
        .sureq_valid (sureq_valid),
        .sureq_ready (sureq_ready),
        .sureq_op    (sureq_op),
        .sureq_addr  (sureq_addr),
        .cpu_lock    (cpu_lock),
        .arr_rd_en   (arr_rd_en),
        .arr_idx     (arr_idx),
        .arr_rd_tag  (arr_rd_tag),
        .arr_rd_st   (arr_rd_st),
        .arr_rd_data (arr_rd_data),
        .arr_wr_en   (arr_wr_en),
        .arr_wr_st   (arr_wr_st),
        .sdrsp_valid (sdrsp_valid),
        .sdrsp_ready (sdrsp_ready),
        .sdrsp_rsp   (sdrsp_rsp),
        .sdrsp_data  (sdrsp_data)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [BW-1:0] rand_blk();
        logic [BW-1:0] b;
        for (int i = 0; i < BW / 32; i++) b[i*32 +: 32] = $urandom;
        return b;
    endfunction

    function automatic logic [2:0] rand_st();
        case ($urandom_range(0, 3))
            0:       return `INVALID;
            1:       return `SHARED;
            2:       return `EXCLUSIVE;
            default: return `MODIFIED;
        endcase
    endfunction

    // Garbage on the read bus outside the cycle the array actually answers
    task automatic scramble_rd();
        arr_rd_tag  = TW'($urandom);
        arr_rd_st   = 3'($urandom);
        arr_rd_data = rand_blk();
    endtask

    // Present a request until accepted, toggling cpu_lock; lock is forced off after a while
    task automatic do_handshake(input logic [1:0] op, input logic [AW-1:0] addr, output bit hs);
        hs = 1'b0;
        for (int k = 0; k < 20 && !hs; k++) begin
            @(posedge clk);
            #1;
            sureq_valid = 1'b1;
            sureq_op    = op;
            sureq_addr  = addr;
            cpu_lock    = (k < 19) ? 1'($urandom) : 1'b0;
            sdrsp_ready = 1'($urandom);
            scramble_rd();
            @(negedge clk);
            check_val("ready_idle", BW'(sureq_ready), BW'(!cpu_lock));
            check_val("idle_no_rsp", BW'(sdrsp_valid), BW'(0));
            if (sureq_ready) begin
                hs = 1'b1;
                check_val("rd_en_accept", BW'(arr_rd_en), BW'(1));
                check_val("rd_idx_accept", BW'(arr_idx), BW'(addr[OW +: IW]));
            end else begin
                check_val("rd_en_locked", BW'(arr_rd_en), BW'(0));
            end
        end
        if (!hs) check_val("accept_timeout", BW'(0), BW'(1));
    endtask

    // One complete snoop transaction checked against the MESI model
    task automatic run_req(input logic [1:0] op, input logic [IW-1:0] idx,
                           input logic [TW-1:0] tag, input int rdy_delay);
        logic [AW-1:0] addr;
        logic [2:0]    old_st;
        logic [2:0]    cur;
        logic [2:0]    nst;
        logic [1:0]    exp_rsp;
        logic [BW-1:0] exp_data;
        bit            hit;
        bit            okay;
        bit            exp_wr;
        bit            hs;
        bit            done;
        int            exp_lat;
        int            first_v;
        int            wr_seen;
        int            wr_n;

        addr     = {tag, idx, OW'($urandom)};
        old_st   = mem_st[idx];
        hit      = (mem_tag[idx] == tag) && (old_st != `INVALID);
        cur      = hit ? old_st : `INVALID;
        okay     = hit && (cur == `MODIFIED || cur == `EXCLUSIVE) &&
                   (op == `SUREQ_RD || op == `SUREQ_RFO);
        if (op == `SUREQ_RD) nst = `SHARED;
        else if (op == `SUREQ_RFO || op == `SUREQ_INV) nst = `INVALID;
        else nst = cur;
        exp_wr   = hit && (nst != cur);
        exp_rsp  = okay ? `SDRSP_OKAY : `SDRSP_INV;
        exp_data = okay ? mem_data[idx] : '0;
        exp_lat  = 3;
`ifdef SNP_FAST_MISS_EN
        if (!hit) exp_lat = 2;
`endif

        do_handshake(op, addr, hs);
        if (!hs) return;

        first_v = -1;
        wr_seen = 0;
        wr_n    = -1;
        done    = 1'b0;
        for (int n = 1; n <= 40 && !done; n++) begin
            @(posedge clk);
            #1;
            sureq_valid = 1'($urandom);
            sureq_op    = 2'($urandom);
            sureq_addr  = $urandom;
            cpu_lock    = 1'($urandom);
            sdrsp_ready = (n >= exp_lat + rdy_delay);
            if (n == 1) begin
                arr_rd_tag  = mem_tag[idx];
                arr_rd_st   = mem_st[idx];
                arr_rd_data = mem_data[idx];
            end else begin
                scramble_rd();
            end
            @(negedge clk);
            check_val("ready_busy", BW'(sureq_ready), BW'(0));
            check_val("rd_en_busy", BW'(arr_rd_en), BW'(0));
            if (arr_wr_en) begin
                wr_seen++;
                wr_n = n;
                check_val("wr_idx", BW'(arr_idx), BW'(idx));
                check_val("wr_state", BW'(arr_wr_st), BW'(nst));
                mem_st[idx] = arr_wr_st;
            end
            if (sdrsp_valid) begin
                if (first_v < 0) begin
                    first_v = n;
                    check_val("rsp_latency", BW'(n), BW'(exp_lat));
                end
                check_val("rsp_code", BW'(sdrsp_rsp), BW'(exp_rsp));
                check_val("rsp_data", sdrsp_data, exp_data);
                if (sdrsp_ready) done = 1'b1;
            end else if (first_v >= 0) begin
                check_val("rsp_valid_dropped", BW'(sdrsp_valid), BW'(1));
            end
        end
        check_val("rsp_handshake", BW'(done), BW'(1));
        check_val("wr_count", BW'(wr_seen), BW'(exp_wr));
        if (exp_wr) check_val("wr_cycle", BW'(wr_n), BW'(2));
        check_val("array_state", BW'(mem_st[idx]), BW'(exp_wr ? nst : old_st));

        // The cycle after the response handshake is already back in IDLE
        @(posedge clk);
        #1;
        sureq_valid = 1'b0;
        cpu_lock    = 1'($urandom);
        sdrsp_ready = 1'b0;
        @(negedge clk);
        check_val("ready_after_rsp", BW'(sureq_ready), BW'(!cpu_lock));
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_ready"}, BW'(sureq_ready), BW'(0));
        check_val({tag, "_rd_en"}, BW'(arr_rd_en), BW'(0));
        check_val({tag, "_wr_en"}, BW'(arr_wr_en), BW'(0));
        check_val({tag, "_valid"}, BW'(sdrsp_valid), BW'(0));
        check_val({tag, "_rsp"}, BW'(sdrsp_rsp), BW'(`SDRSP_INV));
        check_val({tag, "_data"}, sdrsp_data, '0);
        check_val({tag, "_idx"}, BW'(arr_idx), BW'(0));
        check_val({tag, "_wr_st"}, BW'(arr_wr_st), BW'(0));
    endtask

    // Reset while the state write is on the array port: the write and response must vanish
    task automatic run_rst_update();
        logic [AW-1:0] addr;
        bit            hs;
        mem_tag[20]  = TW'($urandom);
        mem_st[20]   = `EXCLUSIVE;
        mem_data[20] = rand_blk();
        addr = {mem_tag[20], 6'd20, 6'd0};
        do_handshake(`SUREQ_RD, addr, hs);
        if (!hs) return;
        for (int n = 1; n <= 2; n++) begin
            @(posedge clk);
            #1;
            sureq_valid = 1'b0;
            sdrsp_ready = 1'b1;
            if (n == 1) begin
                arr_rd_tag  = mem_tag[20];
                arr_rd_st   = mem_st[20];
                arr_rd_data = mem_data[20];
            end else begin
                scramble_rd();
            end
            @(negedge clk);
        end
        check_val("rst_pre_wr_en", BW'(arr_wr_en), BW'(1));
        rst      = 1'b1;
        cpu_lock = 1'b0;
        #1;
        check_reset_outputs("rst_upd");
        @(posedge clk);
        #1;
        check_val("rst_held_ready", BW'(sureq_ready), BW'(0));
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            sureq_valid = 1'b0;
            cpu_lock    = 1'($urandom);
            @(negedge clk);
            check_val("post_rst_valid", BW'(sdrsp_valid), BW'(0));
            check_val("post_rst_wr_en", BW'(arr_wr_en), BW'(0));
            check_val("post_rst_ready", BW'(sureq_ready), BW'(!cpu_lock));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [IW-1:0] idx;
        logic [TW-1:0] tag;

        rst         = 1'b1;
        sureq_valid = 1'b0;
        sureq_op    = `SUREQ_RD;
        sureq_addr  = '0;
        cpu_lock    = 1'b0;
        sdrsp_ready = 1'b0;
        scramble_rd();
        for (int i = 0; i < 64; i++) begin
            mem_tag[i]  = TW'($urandom_range(0, 3));
            mem_st[i]   = rand_st();
            mem_data[i] = rand_blk();
        end
        #1;
        check_reset_outputs("por");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_val("por_release_ready", BW'(sureq_ready), BW'(1));

        // Hit in MODIFIED, read snoop: demote to SHARED, OKAY with data
        mem_tag[5] = 20'h1_2345; mem_st[5] = `MODIFIED;
        run_req(`SUREQ_RD, 6'd5, 20'h1_2345, 0);
        // Hit in SHARED, RFO: evict, INV with zero data
        mem_tag[6] = 20'h0_00aa; mem_st[6] = `SHARED;
        run_req(`SUREQ_RFO, 6'd6, 20'h0_00aa, 0);
        // Tag miss, invalidate: no write
        mem_tag[7] = 20'h0_0777; mem_st[7] = `MODIFIED;
        run_req(`SUREQ_INV, 6'd7, 20'h0_0776, 0);
        // Hit in SHARED, read snoop: state unchanged, no write
        mem_tag[8] = 20'h0_0008; mem_st[8] = `SHARED;
        run_req(`SUREQ_RD, 6'd8, 20'h0_0008, 0);
        // Exclusive hit with response back-pressured for 5 cycles
        mem_tag[9] = 20'h0_0009; mem_st[9] = `EXCLUSIVE;
        run_req(`SUREQ_RFO, 6'd9, 20'h0_0009, 5);
        // Unused op code on a MODIFIED hit leaves the line alone
        mem_tag[10] = 20'h0_000a; mem_st[10] = `MODIFIED;
        run_req(2'd3, 6'd10, 20'h0_000a, 1);

        run_rst_update();

        for (int t = 0; t < 80; t++) begin
            idx = IW'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                mem_st[idx]   = rand_st();
                mem_data[idx] = rand_blk();
            end
            tag = ($urandom_range(0, 3) != 0) ? mem_tag[idx] : TW'($urandom_range(0, 3));
            run_req(2'($urandom), idx, tag, int'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
